// File: rtl/register_file_pkg.sv
// Shared types and constants for the integer register file and its read ports.
package register_file_pkg;

    localparam int XLEN     = 64;
    localparam int NUM_REGS = 32;

    typedef logic [XLEN-1:0]              data_port;
    typedef logic [$clog2(NUM_REGS)-1:0]  reg_addr;

    localparam reg_addr REG_ZERO = '0;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state;

endpackage

// File: rtl/register_file_rf_read_port.sv
// One combinational read port: ready gate, hardwired x0, same-cycle write bypass, array mux.
module rf_read_port
    import register_file_pkg::data_port;
    import register_file_pkg::REG_ZERO;
#(
    parameter int NUM_REGS   = register_file_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  ready_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  data_port              wr_data_i,
    input  data_port              regs_i [NUM_REGS],
    output data_port              rd_data_o
);

    // Until the clear sweep finishes the array may hold garbage, so nothing passes.
    always_comb begin
        rd_data_o = '0;
        if (!ready_i) begin
            rd_data_o = '0;
        end else if (rd_addr_i == ADDR_WIDTH'(REG_ZERO)) begin
            rd_data_o = '0;
        end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_o = wr_data_i;
        end else begin
            rd_data_o = regs_i[rd_addr_i];
        end
    end

endmodule

// File: rtl/register_file.sv
// 32-entry integer register file with post-reset clear sweep and two bypassed read ports.
module register_file
    import register_file_pkg::data_port;
    import register_file_pkg::rf_state;
    import register_file_pkg::RF_CLEAR;
    import register_file_pkg::RF_RUN;
    import register_file_pkg::REG_ZERO;
#(
    parameter int NUM_REGS   = register_file_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  data_port              write_data,
    input  logic                  reg_write,
    output data_port              read_data_1,
    output data_port              read_data_2,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

    rf_state               state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  ready_q, ready_d;
    data_port              regs_q [NUM_REGS];

    logic                  arrWe;
    logic [ADDR_WIDTH-1:0] arrAddr;
    data_port              arrData;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            idx_q   <= FIRST_IDX;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    // The sweep and the writeback stage share the single array write port.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ready_d = ready_q;
        arrWe   = 1'b0;
        arrAddr = idx_q;
        arrData = '0;
        case (state_q)
            RF_CLEAR: begin
                arrWe   = 1'b1;
                arrAddr = idx_q;
                if (idx_q == LAST_IDX) begin
                    state_d = RF_RUN;
                    ready_d = 1'b1;
                end else begin
                    idx_d = idx_q + FIRST_IDX;
                end
            end
            RF_RUN: begin
                if (reg_write && (write_reg != ADDR_WIDTH'(REG_ZERO))) begin
                    arrWe   = 1'b1;
                    arrAddr = write_reg;
                    arrData = write_data;
                end
            end
            default: state_d = RF_CLEAR;
        endcase
    end

    // Array contents are deliberately left alone by reset; the sweep clears them.
    always_ff @(posedge clk) begin
        if (rst_n && arrWe) begin
            regs_q[arrAddr] <= arrData;
        end
    end

    assign ready = ready_q;

    rf_read_port #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_read_1 (
        .ready_i   (ready_q),
        .rd_addr_i (read_reg_1),
        .wr_en_i   (reg_write),
        .wr_addr_i (write_reg),
        .wr_data_i (write_data),
        .regs_i    (regs_q),
        .rd_data_o (read_data_1)
    );

    rf_read_port #(.NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH)) u_read_2 (
        .ready_i   (ready_q),
        .rd_addr_i (read_reg_2),
        .wr_en_i   (reg_write),
        .wr_addr_i (write_reg),
        .wr_data_i (write_data),
        .regs_i    (regs_q),
        .rd_data_o (read_data_2)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file: clear sweep, writes, bypass, x0 and resets.
module tb_register_file;
    import register_file_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [4:0] read_reg_1;
    logic [4:0] read_reg_2;
    logic [4:0] write_reg;
    data_port   write_data;
    logic       reg_write;
    data_port   read_data_1;
    data_port   read_data_2;
    logic       ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       we;
        logic [4:0] wa;
        data_port   wd;
        logic [4:0] r1;
        logic [4:0] r2;
        data_port   e1;
        data_port   e2;
    } vec_t;

    vec_t vecs [12];

    register_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_reg_1  (read_reg_1),
        .read_reg_2  (read_reg_2),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .reg_write   (reg_write),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic we, input logic [4:0] wa, input data_port wd,
                                 input logic [4:0] r1, input logic [4:0] r2);
        reg_write  = we;
        write_reg  = wa;
        write_data = wd;
        read_reg_1 = r1;
        read_reg_2 = r2;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;

        // RUN-phase vectors; expected reads are the combinational values before the edge.
        vecs[0]  = '{1'b1, 5'd7,  64'h0000_0000_DEAD_BEEF, 5'd7,  5'd7,  64'h0000_0000_DEAD_BEEF, 64'h0000_0000_DEAD_BEEF};
        vecs[1]  = '{1'b0, 5'd0,  64'h0,                   5'd7,  5'd0,  64'h0000_0000_DEAD_BEEF, 64'h0};
        vecs[2]  = '{1'b1, 5'd3,  64'h1234,                5'd3,  5'd3,  64'h1234,                64'h1234};
        vecs[3]  = '{1'b0, 5'd0,  64'h0,                   5'd3,  5'd7,  64'h1234,                64'h0000_0000_DEAD_BEEF};
        vecs[4]  = '{1'b1, 5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 5'd0,  5'd0,  64'h0,                   64'h0};
        vecs[5]  = '{1'b0, 5'd0,  64'h0,                   5'd7,  5'd0,  64'h0000_0000_DEAD_BEEF, 64'h0};
        vecs[6]  = '{1'b1, 5'd31, 64'hA5A5_A5A5_5A5A_5A5A, 5'd31, 5'd3,  64'hA5A5_A5A5_5A5A_5A5A, 64'h1234};
        vecs[7]  = '{1'b1, 5'd3,  64'h5678,                5'd3,  5'd31, 64'h5678,                64'hA5A5_A5A5_5A5A_5A5A};
        vecs[8]  = '{1'b0, 5'd3,  64'h9999,                5'd3,  5'd1,  64'h5678,                64'h0};
        vecs[9]  = '{1'b0, 5'd0,  64'h0,                   5'd3,  5'd31, 64'h5678,                64'hA5A5_A5A5_5A5A_5A5A};
        vecs[10] = '{1'b1, 5'd9,  64'h55,                  5'd9,  5'd4,  64'h55,                  64'h0};
        vecs[11] = '{1'b0, 5'd0,  64'h0,                   5'd9,  5'd5,  64'h55,                  64'h0};

        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd5, 5'd31);

        tick();
        tick();
        checkOutput("reset_ready", {63'd0, ready}, 64'd0);
        checkOutput("reset_rd1", read_data_1, 64'd0);
        checkOutput("reset_rd2", read_data_2, 64'd0);
        rst_n = 1'b1;

        // Clear sweep with an attempted write at sweep edge 10.
        for (int k = 1; k <= 31; k++) begin
            if (k == 10) applyStimulus(1'b1, 5'd4, 64'hAA, 5'd5, 5'd31);
            else         applyStimulus(1'b0, 5'd0, 64'h0,  5'd5, 5'd31);
            tick();
            checkOutput($sformatf("sweep_ready_e%0d", k), {63'd0, ready}, (k == 31) ? 64'd1 : 64'd0);
            checkOutput($sformatf("sweep_rd1_e%0d", k), read_data_1, 64'd0);
            checkOutput($sformatf("sweep_rd2_e%0d", k), read_data_2, 64'd0);
        end

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r1, vecs[i].r2);
            #1;
            checkOutput($sformatf("vec%0d_rd1", i), read_data_1, vecs[i].e1);
            checkOutput($sformatf("vec%0d_rd2", i), read_data_2, vecs[i].e2);
            checkOutput($sformatf("vec%0d_ready", i), {63'd0, ready}, 64'd1);
            tick();
        end

        // x0 write: read port 2 stays zero on the write cycle and the cycle after.
        applyStimulus(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 5'd0);
        #1;
        checkOutput("x0_same_cycle", read_data_2, 64'd0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd3, 5'd0);
        #1;
        checkOutput("x0_next_cycle", read_data_2, 64'd0);
        checkOutput("x0_x3_intact", read_data_1, 64'h5678);

        // Reset, then reset again at sweep edge 5; the sweep must restart in full.
        applyStimulus(1'b0, 5'd0, 64'h0, 5'd9, 5'd7);
        rst_n = 1'b0;
        tick();
        checkOutput("rst1_ready", {63'd0, ready}, 64'd0);
        checkOutput("rst1_rd1", read_data_1, 64'd0);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        checkOutput("midsweep_ready", {63'd0, ready}, 64'd0);
        rst_n = 1'b0;
        tick();
        checkOutput("rst2_ready", {63'd0, ready}, 64'd0);
        rst_n = 1'b1;
        cnt = 0;
        while (!ready && cnt < 40) begin
            tick();
            cnt++;
        end
        checkOutput("restart_edges", 64'(cnt), 64'd31);
        checkOutput("restart_x9", read_data_1, 64'd0);
        checkOutput("restart_x7", read_data_2, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
